// File: rtl/idli_pkg.sv
// idli_pkg: types and constants shared by the idli core blocks.
//   mem_state_t  - memory sequencer FSM states
//   sqi_mode_t   - SQI pad bus direction (block drives / block samples)
//   MEM_CMD_*    - SQI RAM command bytes
//   MEM_*_LEN    - nibble counts of each sequencer phase
//   mem_last()   - true in the final cycle of a timed sequencer phase
package idli_pkg;

  typedef enum logic [2:0] {
    MEM_IDLE  = 3'd0,
    MEM_CMD   = 3'd1,
    MEM_ADDR  = 3'd2,
    MEM_DUMMY = 3'd3,
    MEM_DATA  = 3'd4,
    MEM_END   = 3'd5
  } mem_state_t;

  typedef enum logic {
    SQI_MODE_OUT = 1'b0,
    SQI_MODE_IN  = 1'b1
  } sqi_mode_t;

  localparam logic [7:0] MEM_CMD_RD = 8'h03;
  localparam logic [7:0] MEM_CMD_WR = 8'h02;

  localparam logic [2:0] MEM_CMD_LEN   = 3'd2;
  localparam logic [2:0] MEM_ADDR_LEN  = 3'd6;
  localparam logic [2:0] MEM_DUMMY_LEN = 3'd2;
  localparam logic [2:0] MEM_DATA_LEN  = 3'd4;

  // Nibble counter restarts at zero on every state change, so a phase of
  // length N is finished when the counter reads N-1.
  function automatic logic mem_last(input mem_state_t st, input logic [2:0] cnt);
    logic r;
    r = 1'b0;
    case (st)
      MEM_CMD:   r = (cnt == MEM_CMD_LEN   - 3'd1);
      MEM_ADDR:  r = (cnt == MEM_ADDR_LEN  - 3'd1);
      MEM_DUMMY: r = (cnt == MEM_DUMMY_LEN - 3'd1);
      MEM_DATA:  r = (cnt == MEM_DATA_LEN  - 3'd1);
      MEM_END:   r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/idli_mem_arb_m.sv
// idli_mem_arb_m: arbiter and SQI sequencer for the single SQI RAM.
// Shares the RAM between the fetch requester (F, read only) and the
// load/store requester (D), and turns each granted 16-bit word access into a
// command / address / (dummy) / data nibble sequence on the SQI pads.
// Ports:
//   i_mem_gck, i_mem_rst          clock, async active-high reset
//   i_mem_f_req/_addr             fetch request and word address
//   o_mem_f_gnt, o_mem_f_done     fetch grant pulse, fetch data-valid pulse
//   i_mem_d_req/_wr/_addr/_wdata  load/store request, op, address, store data
//   o_mem_d_gnt, o_mem_d_done     data grant pulse, data done pulse
//   o_mem_rdata                   read word, valid during a done pulse
//   o_mem_sqi_cs                  chip select, active-low
//   o_mem_sqi_mode                0 = block drives bus, 1 = block samples bus
//   o_mem_sqi_data, i_mem_sqi_data  outgoing / incoming nibble
module idli_mem_arb_m
  import idli_pkg::*;
(
  input  logic        i_mem_gck,
  input  logic        i_mem_rst,
  input  logic        i_mem_f_req,
  input  logic [15:0] i_mem_f_addr,
  output logic        o_mem_f_gnt,
  output logic        o_mem_f_done,
  input  logic        i_mem_d_req,
  input  logic        i_mem_d_wr,
  input  logic [15:0] i_mem_d_addr,
  input  logic [15:0] i_mem_d_wdata,
  output logic        o_mem_d_gnt,
  output logic        o_mem_d_done,
  output logic [15:0] o_mem_rdata,
  output logic        o_mem_sqi_cs,
  output logic        o_mem_sqi_mode,
  output logic [3:0]  o_mem_sqi_data,
  input  logic [3:0]  i_mem_sqi_data
);

  mem_state_t  r_state;
  mem_state_t  w_next;
  logic [2:0]  r_cnt;
  logic [1:0]  r_starve;
  logic        r_is_d;
  logic        r_wr;
  logic        r_f_gnt;
  logic        r_d_gnt;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [23:0] r_osh;
  logic [15:0] r_ish;

  logic        w_last;
  logic        w_f_win;
  logic        w_d_win;
  logic [7:0]  w_cmd;
  sqi_mode_t   w_mode;

  assign w_last = mem_last(r_state, r_cnt);

  // F wins when D is idle or after D has been granted twice over a waiting F.
  assign w_f_win = (r_state == MEM_IDLE) && i_mem_f_req &&
                   (!i_mem_d_req || (r_starve == 2'd2));
  assign w_d_win = (r_state == MEM_IDLE) && i_mem_d_req && !w_f_win;

  assign w_cmd = (w_d_win && i_mem_d_wr) ? MEM_CMD_WR : MEM_CMD_RD;

  always_comb begin
    w_next = r_state;
    case (r_state)
      MEM_IDLE:  if (w_f_win || w_d_win) w_next = MEM_CMD;
      MEM_CMD:   if (w_last) w_next = MEM_ADDR;
      MEM_ADDR:  if (w_last) w_next = r_wr ? MEM_DATA : MEM_DUMMY;
      MEM_DUMMY: if (w_last) w_next = MEM_DATA;
      MEM_DATA:  if (w_last) w_next = MEM_END;
      MEM_END:   w_next = MEM_IDLE;
      default:   w_next = MEM_IDLE;
    endcase
  end

  // Control state: FSM, counters, grants, latched op and the read word.
  always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
    if (i_mem_rst) begin
      r_state  <= MEM_IDLE;
      r_cnt    <= 3'd0;
      r_starve <= 2'd0;
      r_is_d   <= 1'b0;
      r_wr     <= 1'b0;
      r_f_gnt  <= 1'b0;
      r_d_gnt  <= 1'b0;
      r_ish    <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
      r_f_gnt <= w_f_win;
      r_d_gnt <= w_d_win;

      if (w_f_win) begin
        r_starve <= 2'd0;
      end else if (w_d_win && i_mem_f_req && (r_starve != 2'd2)) begin
        r_starve <= r_starve + 2'd1;
      end

      if (w_f_win || w_d_win) begin
        r_is_d <= w_d_win;
        r_wr   <= w_d_win && i_mem_d_wr;
      end

      // Read nibbles arrive MSB first; sampled at the end of each DATA cycle.
      if ((r_state == MEM_DATA) && !r_wr) begin
        r_ish <= {r_ish[11:0], i_mem_sqi_data};
      end
    end
  end

  // Outgoing datapath: command first, address reloaded on ADDR entry,
  // store data reloaded on DATA entry; the top nibble is always on the pads.
  always_ff @(posedge i_mem_gck) begin
    if (w_f_win || w_d_win) begin
      r_addr  <= w_f_win ? i_mem_f_addr : i_mem_d_addr;
      r_wdata <= i_mem_d_wdata;
      r_osh   <= {w_cmd, 16'h0000};
    end else if ((r_state == MEM_CMD) && w_last) begin
      r_osh <= {7'b0, r_addr, 1'b0};
    end else if ((r_state == MEM_ADDR) && w_last && r_wr) begin
      r_osh <= {r_wdata, 8'h00};
    end else begin
      r_osh <= {r_osh[19:0], 4'h0};
    end
  end

  always_comb begin
    w_mode = SQI_MODE_OUT;
    if ((r_state == MEM_DUMMY) || ((r_state == MEM_DATA) && !r_wr)) begin
      w_mode = SQI_MODE_IN;
    end
  end

  assign o_mem_sqi_mode = w_mode;
  assign o_mem_sqi_cs   = !((r_state == MEM_CMD)   || (r_state == MEM_ADDR) ||
                            (r_state == MEM_DUMMY) || (r_state == MEM_DATA));
  // Data output is gated by state so the pads read zero whenever not driving.
  assign o_mem_sqi_data = ((r_state == MEM_CMD) || (r_state == MEM_ADDR) ||
                           ((r_state == MEM_DATA) && r_wr)) ? r_osh[23:20] : 4'h0;

  assign o_mem_f_gnt  = r_f_gnt;
  assign o_mem_d_gnt  = r_d_gnt;
  assign o_mem_f_done = (r_state == MEM_END) && !r_is_d;
  assign o_mem_d_done = (r_state == MEM_END) && r_is_d;
  assign o_mem_rdata  = r_ish;

endmodule

// File: tb/tb_idli_mem_arb_m.sv
module tb_idli_mem_arb_m;
  import idli_pkg::*;

  logic        clk;
  logic        rst;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_done;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [15:0] rdata;
  logic        cs;
  logic        mode;
  logic [3:0]  sqi_out;
  logic [3:0]  sqi_in;

  int n_total;
  int n_bad;

  idli_mem_arb_m dut (
    .i_mem_gck      (clk),
    .i_mem_rst      (rst),
    .i_mem_f_req    (f_req),
    .i_mem_f_addr   (f_addr),
    .o_mem_f_gnt    (f_gnt),
    .o_mem_f_done   (f_done),
    .i_mem_d_req    (d_req),
    .i_mem_d_wr     (d_wr),
    .i_mem_d_addr   (d_addr),
    .i_mem_d_wdata  (d_wdata),
    .o_mem_d_gnt    (d_gnt),
    .o_mem_d_done   (d_done),
    .o_mem_rdata    (rdata),
    .o_mem_sqi_cs   (cs),
    .o_mem_sqi_mode (mode),
    .o_mem_sqi_data (sqi_out),
    .i_mem_sqi_data (sqi_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_cs"},     cs,      1);
    chk({tag, "_mode"},   mode,    0);
    chk({tag, "_data"},   sqi_out, 0);
    chk({tag, "_fgnt"},   f_gnt,   0);
    chk({tag, "_dgnt"},   d_gnt,   0);
    chk({tag, "_fdone"},  f_done,  0);
    chk({tag, "_ddone"},  d_done,  0);
    chk({tag, "_rdata"},  rdata,   0);
  endtask

  // Runs one access from the IDLE sample cycle (cycle 0) through the IDLE
  // cycle after END. stream holds the expected outgoing nibbles, first at
  // the top: command, address, then store data for writes.
  task automatic run_txn(input bit is_d, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] rword,
                         input logic [47:0] stream, input string nm);
    int dc;
    logic [3:0] exp_d;
    dc = wr ? 13 : 15;
    if (is_d) begin
      d_addr = addr; d_wdata = wdata; d_wr = wr; d_req = 1'b1;
    end else begin
      f_addr = addr; f_req = 1'b1;
    end
    for (int k = 1; k <= dc + 1; k++) begin
      @(negedge clk);
      chk($sformatf("%s_fgnt_c%0d", nm, k), f_gnt, (!is_d && k == 1));
      chk($sformatf("%s_dgnt_c%0d", nm, k), d_gnt, (is_d && k == 1));
      if (k == 1) begin
        if (is_d) d_req = 1'b0; else f_req = 1'b0;
      end
      chk($sformatf("%s_cs_c%0d", nm, k), cs, (k < dc) ? 1'b0 : 1'b1);
      chk($sformatf("%s_mode_c%0d", nm, k), mode, (!wr && k >= 9 && k <= 14));
      exp_d = 4'h0;
      if (k <= 8 || (wr && k <= 12)) exp_d = stream[47 - 4*(k-1) -: 4];
      chk($sformatf("%s_nib_c%0d", nm, k), sqi_out, exp_d);
      chk($sformatf("%s_fdone_c%0d", nm, k), f_done, (!is_d && k == dc));
      chk($sformatf("%s_ddone_c%0d", nm, k), d_done, (is_d && k == dc));
      if (!wr && k == dc) chk({nm, "_rdata"}, rdata, rword);
      if (!wr && k >= 11 && k <= 14) sqi_in = rword[15 - 4*(k-11) -: 4];
      else sqi_in = 4'h0;
    end
  endtask

  initial begin
    int ngnt;
    bit exp_d_order [6];
    logic [1:0] exp_starve [6];

    n_total = 0; n_bad = 0;
    rst = 1'b1;
    f_req = 1'b0; f_addr = 16'h0;
    d_req = 1'b0; d_wr = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
    sqi_in = 4'h0;

    repeat (2) @(negedge clk);
    chk_reset_outs("rst0");
    rst = 1'b0;
    @(negedge clk);

    // F read of 0x1234; RAM returns A,B,C,D.
    run_txn(1'b0, 1'b0, 16'h1234, 16'h0, 16'hABCD, 48'h030024680000, "frd");

    // D write of 0xBEEF to word 0x0001.
    run_txn(1'b1, 1'b1, 16'h0001, 16'hBEEF, 16'h0, 48'h02000002BEEF, "dwr");

    // D raises and drops its request while an F read is busy: never granted.
    fork
      run_txn(1'b0, 1'b0, 16'h0002, 16'h0, 16'h1357, 48'h030000040000, "drp");
      begin
        repeat (4) @(negedge clk);
        d_req = 1'b1; d_wr = 1'b0;
        repeat (6) @(negedge clk);
        d_req = 1'b0;
      end
    join
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drp_after_dgnt_%0d", i), d_gnt, 0);
      chk($sformatf("drp_after_cs_%0d", i), cs, 1);
    end

    // Reset in cycle 11 of a read aborts it.
    f_addr = 16'h00A5; f_req = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) f_req = 1'b0;
      if (k == 11) chk("mid_cs_before", cs, 0);
    end
    sqi_in = 4'h7;
    rst = 1'b1;
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    chk("mid_hold_fdone", f_done, 0);
    chk("mid_hold_cs", cs, 1);
    rst = 1'b0;
    sqi_in = 4'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_fdone_%0d", i), f_done, 0);
      chk($sformatf("post_rst_cs_%0d", i), cs, 1);
    end
    run_txn(1'b0, 1'b0, 16'h0ABC, 16'h0, 16'h5A3C, 48'h030015780000, "rrd");

    // Both requesters held high: grant order D, D, F, D, D, F.
    exp_d_order[0] = 1'b1; exp_starve[0] = 2'd1;
    exp_d_order[1] = 1'b1; exp_starve[1] = 2'd2;
    exp_d_order[2] = 1'b0; exp_starve[2] = 2'd0;
    exp_d_order[3] = 1'b1; exp_starve[3] = 2'd1;
    exp_d_order[4] = 1'b1; exp_starve[4] = 2'd2;
    exp_d_order[5] = 1'b0; exp_starve[5] = 2'd0;
    f_addr = 16'h0100; d_addr = 16'h0200; d_wdata = 16'h1111; d_wr = 1'b1;
    f_req = 1'b1; d_req = 1'b1;
    ngnt = 0;
    for (int c = 0; c < 300 && ngnt < 6; c++) begin
      @(negedge clk);
      if (f_gnt || d_gnt) begin
        chk($sformatf("arb_both_gnt_%0d", ngnt), {f_gnt, d_gnt} != 2'b11, 1);
        chk($sformatf("arb_order_%0d", ngnt), d_gnt, exp_d_order[ngnt]);
        chk($sformatf("arb_starve_%0d", ngnt), dut.r_starve, exp_starve[ngnt]);
        ngnt++;
      end
    end
    chk("arb_gnt_count", ngnt, 6);
    f_req = 1'b0; d_req = 1'b0;
    repeat (20) @(negedge clk);
    chk("arb_end_cs", cs, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/idli_mem_arb_m.md
# idli_mem_arb_m

Memory arbiter and sequencer for the single SQI RAM. It shares the RAM between the core's instruction-fetch requester (F) and load/store requester (D), and serialises each granted 16-bit word access into an SQI command/address/data nibble sequence on the pad interface. It sits between the core pipeline and the SQI pads, and owns chip-select, bus direction and outgoing nibbles.

## Interface
- No parameters. Word size 16 bits, nibble bus 4 bits, RAM byte address 24 bits; all fixed.
- i_mem_gck  in  1  clock; everything in this block is clocked on its rising edge
- i_mem_rst  in  1  reset, asynchronous, active-high
- i_mem_f_req  in  1  fetch request, held until grant
- i_mem_f_addr  in  16  fetch word address
- o_mem_f_gnt  out  1  one-cycle fetch grant pulse
- o_mem_f_done  out  1  one-cycle pulse, fetch data valid on o_mem_rdata
- i_mem_d_req  in  1  data request, held until grant
- i_mem_d_wr  in  1  1 = store, 0 = load
- i_mem_d_addr  in  16  data word address
- i_mem_d_wdata  in  16  store data
- o_mem_d_gnt  out  1  one-cycle data grant pulse
- o_mem_d_done  out  1  one-cycle pulse, load data valid / store complete
- o_mem_rdata  out  16  read data, valid only while a done pulse is high
- o_mem_sqi_cs  out  1  chip select, active-low
- o_mem_sqi_mode  out  1  0 = block drives bus, 1 = block samples bus
- o_mem_sqi_data  out  4  outgoing nibble
- i_mem_sqi_data  in  4  incoming nibble

## Operation
- FSM states and lengths in cycles: IDLE, CMD (2), ADDR (6), DUMMY (2, reads only), DATA (4), END (1). A 3-bit nibble counter tracks progress; it resets on every state change.
- IDLE: the block samples the requests. If neither request is high, it stays in IDLE. Otherwise it picks a winner, latches that winner's op, address and wdata, and goes to CMD.
- Fetch is always a read.
- Arbitration:
  - D wins by default.
  - F wins when D is idle.
  - F also wins when the starve counter equals 2.
- Starve counter (2 bits):
  - Increments on a D grant while F is requesting.
  - Clears on any F grant.
  - Saturates at 2.
- Command byte: 0x03 for a read, 0x02 for a write. It is sent high nibble first.
- Address: byte address {7'b0, addr[15:0], 1'b0}, sent as 6 nibbles MSB first. Example: word 0x1234 gives nibbles 0,0,2,4,6,8.
- DUMMY: the bus is turned around; o_mem_sqi_mode=1 and the data drives 0.
- DATA, write: wdata is shifted out MSB nibble first, with mode=0.
- DATA, read: mode=1. i_mem_sqi_data is sampled at the end of each DATA cycle and shifted into rdata, MSB first.
- END: cs=1, mode=0. The requester's done pulse is raised; for reads, rdata holds the assembled word. The FSM then returns to IDLE.
- cs=0 in CMD, ADDR, DUMMY and DATA; cs=1 in IDLE and END.
- Requests may drop before grant. In that case no grant is issued, and a requester that drops gets nothing.
- Address and wdata must be stable only in the IDLE cycle where the request wins.

## Timing
- Reset values, held throughout reset:
  - o_mem_sqi_cs=1, mode=0, o_mem_sqi_data=0
  - both gnt=0, both done=0, o_mem_rdata=0
  - state IDLE, starve counter 0
- Reset asserted mid-transaction aborts immediately and asynchronously: cs goes high and no done pulse is issued.
- The gnt pulse is registered and is high in the first CMD cycle.
- Read: req sampled in cycle 0; CMD cycles 1–2, ADDR 3–8, DUMMY 9–10, DATA 11–14; done in cycle 15 (END); IDLE in cycle 16.
- Write: DATA cycles 9–12; done in cycle 13.
- Back-to-back accesses: at least one IDLE cycle and one END cycle separate them, so cs is high for at least 2 cycles between transactions.
- Requests arriving outside IDLE are ignored until IDLE. This includes a request raised during the END of the requester's own previous access.
- o_mem_rdata is unchanged outside read DATA shifting.

## Structure
- Add to idli_pkg:
  - mem_state_t enum (IDLE, CMD, ADDR, DUMMY, DATA, END)
  - constants MEM_CMD_RD=8'h03 and MEM_CMD_WR=8'h02
  - sqi_mode_t reused for mode
- No sub-module; the arbitration decision and the shift registers are inline.
- One 24-bit outgoing shift register (command, then address, then wdata reloaded at the DATA entry) and one 16-bit incoming shift register.

## Test plan
- F read of 0x1234, RAM returns nibbles A,B,C,D:
  - gnt in cycle 1
  - out nibbles 0,3,0,0,2,4,6,8
  - f_done in cycle 15 with rdata=0xABCD
  - cs low for cycles 1–14
- D write of 0xBEEF to 0x0001:
  - out nibbles 0,2,0,0,0,0,0,2,B,E,E,F
  - mode 0 throughout
  - d_done in cycle 13, no f_done
- F and D request simultaneously and continuously:
  - grant order D, D, F, D, D, F
  - starve counter clears after each F grant
- D request raised then dropped before IDLE: no d_gnt, cs stays 1.
- Reset asserted in cycle 11 of a read:
  - cs=1 and all outputs at reset values in the same cycle
  - no done pulse
  - after reset release, a new F request completes normally with its own data.
